// File: rtl/weight_ram_ctrl_pkg.sv
// Shared constants, state encoding and write-beat payload for the weight RAM controller.
package weight_ram_ctrl_pkg;

  localparam int unsigned DATA_WIDTH              = 16;
  localparam int unsigned KERNEL_SIZE_MAX         = 5;
  localparam int unsigned WEIGHT_RAM_MAX          = 100;
  localparam int unsigned SLICE_PITCH             = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
  localparam int unsigned SLICE_MAX               = WEIGHT_RAM_MAX / SLICE_PITCH;
  localparam int unsigned WEIGHT_READ_ADDR_WIDTH  = 10;
  localparam int unsigned WEIGHT_WRITE_ADDR_WIDTH = 5;
  localparam int unsigned SLICE_DATA_WIDTH        = SLICE_PITCH * DATA_WIDTH;

  localparam int unsigned KS_WIDTH        = 3;
  localparam int unsigned NS_WIDTH        = 3;
  localparam int unsigned IDX_WIDTH       = 5;  // in-slice index, up to 24
  localparam int unsigned SLICE_CNT_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // One accepted loader beat, held until the RAM write cycle.
  typedef struct packed {
    logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] slice;
    logic [SLICE_DATA_WIDTH-1:0]        data;
  } wr_beat_t;

  // Only square kernels of odd size 1, 3 or 5 are supported.
  function automatic logic ks_legal(input logic [KS_WIDTH-1:0] ks);
    return (ks == 3'd1) || (ks == 3'd3) || (ks == 3'd5);
  endfunction

endpackage

// File: rtl/weight_addr_gen.sv
// Slice/index counters producing the streaming read address and last-address flag.
module weight_addr_gen
  import weight_ram_ctrl_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load,
  input  logic                              adv,
  input  logic [KS_WIDTH-1:0]               ks,
  input  logic [NS_WIDTH-1:0]               ns,
  output logic [WEIGHT_READ_ADDR_WIDTH-1:0] addr,
  output logic                              last_c
);

  logic [SLICE_CNT_WIDTH-1:0]        s_q, s_d;
  logic [IDX_WIDTH-1:0]              i_q, i_d;
  logic [IDX_WIDTH-1:0]              kk_last_q, kk_last_d;
  logic [NS_WIDTH-1:0]               ns_last_q, ns_last_d;
  logic [WEIGHT_READ_ADDR_WIDTH-1:0] base_q, base_d;
  logic [WEIGHT_READ_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [IDX_WIDTH-1:0]              ks_w;

  assign ks_w   = IDX_WIDTH'(ks);
  assign addr   = addr_q;
  assign last_c = (s_q == ns_last_q) && (i_q == kk_last_q);

  // Address kept as slice base + index; the base steps by the slice pitch on wrap.
  always_comb begin
    s_d       = s_q;
    i_d       = i_q;
    kk_last_d = kk_last_q;
    ns_last_d = ns_last_q;
    base_d    = base_q;
    addr_d    = addr_q;
    if (load) begin
      s_d       = '0;
      i_d       = '0;
      base_d    = '0;
      addr_d    = '0;
      kk_last_d = IDX_WIDTH'(ks_w * ks_w - IDX_WIDTH'(1));
      ns_last_d = NS_WIDTH'(ns - NS_WIDTH'(1));
    end else if (adv && !last_c) begin
      if (i_q == kk_last_q) begin
        i_d    = '0;
        s_d    = SLICE_CNT_WIDTH'(s_q + SLICE_CNT_WIDTH'(1));
        base_d = WEIGHT_READ_ADDR_WIDTH'(base_q + WEIGHT_READ_ADDR_WIDTH'(SLICE_PITCH));
        addr_d = WEIGHT_READ_ADDR_WIDTH'(base_q + WEIGHT_READ_ADDR_WIDTH'(SLICE_PITCH));
      end else begin
        i_d    = IDX_WIDTH'(i_q + IDX_WIDTH'(1));
        addr_d = WEIGHT_READ_ADDR_WIDTH'(addr_q + WEIGHT_READ_ADDR_WIDTH'(1));
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      i_q       <= '0;
      kk_last_q <= '0;
      ns_last_q <= '0;
      base_q    <= '0;
      addr_q    <= '0;
    end else begin
      s_q       <= s_d;
      i_q       <= i_d;
      kk_last_q <= kk_last_d;
      ns_last_q <= ns_last_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
    end
  end

endmodule

// File: rtl/weight_ram_ctrl.sv
// Weight RAM sequencer: arbitrates loader slice writes against weight streaming to the PE.
module weight_ram_ctrl
  import weight_ram_ctrl_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] wr_slice,
  input  logic [SLICE_DATA_WIDTH-1:0]        wr_data,
  input  logic                               start,
  input  logic [KS_WIDTH-1:0]                kernel_size,
  input  logic [NS_WIDTH-1:0]                num_slices,
  output logic                               busy,
  output logic                               ram_ena_wr,
  output logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] ram_addr_write,
  output logic [SLICE_DATA_WIDTH-1:0]        ram_din,
  output logic [WEIGHT_READ_ADDR_WIDTH-1:0]  ram_addr_read,
  input  logic [DATA_WIDTH-1:0]              ram_dout,
  output logic                               w_valid,
  output logic [DATA_WIDTH-1:0]              w_data,
  output logic                               w_last,
  output logic                               done,
  output logic                               err
);

  state_e   state_q, state_d;
  wr_beat_t wr_q, wr_d;
  logic     ram_ena_wr_q, ram_ena_wr_d;
  logic     busy_q, busy_d;
  logic     w_valid_q, w_valid_d;
  logic     w_last_q, w_last_d;
  logic     done_q, done_d;
  logic     err_q, err_d;
  logic     load_c;
  logic     last_c;
  logic     start_bad_c;

  // Start takes priority over a pending write in the same cycle.
  assign wr_ready    = (state_q == ST_IDLE) && !start;
  assign start_bad_c = !ks_legal(kernel_size) || (num_slices > NS_WIDTH'(SLICE_MAX));

  assign busy           = busy_q;
  assign ram_ena_wr     = ram_ena_wr_q;
  assign ram_addr_write = wr_q.slice;
  assign ram_din        = wr_q.data;
  assign w_valid        = w_valid_q;
  assign w_data         = ram_dout;
  assign w_last         = w_last_q;
  assign done           = done_q;
  assign err            = err_q;

  weight_addr_gen u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_c),
    .adv    (state_q == ST_READ),
    .ks     (kernel_size),
    .ns     (num_slices),
    .addr   (ram_addr_read),
    .last_c (last_c)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    ram_ena_wr_d = 1'b0;
    w_valid_d    = 1'b0;
    w_last_d     = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    load_c       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_bad_c) begin
            err_d = 1'b1;
          end else if (num_slices == '0) begin
            done_d = 1'b1;
          end else begin
            load_c  = 1'b1;
            state_d = ST_READ;
          end
        end else if (wr_valid) begin
          if (wr_slice >= WEIGHT_WRITE_ADDR_WIDTH'(SLICE_MAX)) begin
            err_d = 1'b1;
          end else begin
            wr_d.slice   = wr_slice;
            wr_d.data    = wr_data;
            ram_ena_wr_d = 1'b1;
            state_d      = ST_WRITE;
          end
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ: begin
        // Data for this cycle's address appears next cycle, so valid is delayed by one.
        w_valid_d = 1'b1;
        if (last_c) begin
          w_last_d = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_READ) || (state_d == ST_DRAIN);
  end

  // State and output registers; reset drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_q         <= '0;
      ram_ena_wr_q <= 1'b0;
      busy_q       <= 1'b0;
      w_valid_q    <= 1'b0;
      w_last_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      ram_ena_wr_q <= ram_ena_wr_d;
      busy_q       <= busy_d;
      w_valid_q    <= w_valid_d;
      w_last_q     <= w_last_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule
